// File: rtl/xga_timing_gen.sv
// Raster timing generator for 1024x768@60 (XGA): pixel counters, syncs, active window, line/frame strobes.
// Optional macro XGA_FRAME_COUNT_EN adds a 10-bit frame counter output (frame_count).
module xga_timing_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        video_active,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start
`ifdef XGA_FRAME_COUNT_EN
    ,
    output logic [9:0]  frame_count
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] Y_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] X_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] Y_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 2047) begin : g_bad_h_total
        $error("xga_timing_gen: H_TOTAL exceeds 2047");
    end
    if (V_TOTAL > 2047) begin : g_bad_v_total
        $error("xga_timing_gen: V_TOTAL exceeds 2047");
    end

    // Next raster position and its decodes; registering the decodes of the
    // next position keeps every level output aligned with pix_x/pix_y.
    logic        wrap_x;
    logic        wrap_y;
    logic [10:0] next_x;
    logic [10:0] next_y;
    logic        next_active;
    logic        next_hs;
    logic        next_vs;

    always_comb begin
        wrap_x      = (pix_x == X_LAST);
        wrap_y      = (pix_y == Y_LAST);
        next_x      = pix_x + 11'd1;
        next_y      = pix_y;
        if (wrap_x) begin
            next_x = 11'd0;
            next_y = wrap_y ? 11'd0 : (pix_y + 11'd1);
        end
        next_active = (next_x < X_ACT) && (next_y < Y_ACT);
        next_hs     = (next_x >= HS_START) && (next_x < HS_END);
        next_vs     = (next_y >= VS_START) && (next_y < VS_END);
    end

    // pix_en is a plain qualifier with no handshake: a clk edge with pix_en=1
    // advances one pixel, pix_en=0 holds all levels and drops both strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_x        <= X_LAST;
            pix_y        <= Y_LAST;
            video_active <= 1'b0;
            hsync        <= ~SYNC_POL;
            vsync        <= ~SYNC_POL;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else if (pix_en) begin
            pix_x        <= next_x;
            pix_y        <= next_y;
            video_active <= next_active;
            hsync        <= next_hs ? SYNC_POL : ~SYNC_POL;
            vsync        <= next_vs ? SYNC_POL : ~SYNC_POL;
            line_start   <= wrap_x;
            frame_start  <= wrap_x && wrap_y;
        end else begin
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end
    end

`ifdef XGA_FRAME_COUNT_EN
    // Bumps on the same edge that raises frame_start, so both appear together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= 10'd0;
        end else if (pix_en && wrap_x && wrap_y) begin
            frame_count <= frame_count + 10'd1;
        end
    end
`endif

endmodule

// File: tb/tb_xga_timing_gen.sv
// Directed bench for xga_timing_gen: full-size instance for reset/line timing,
// a shrunken raster instance for frame-level, pix_en gating and async reset checks.
module tb_xga_timing_gen;

    logic clk;
    logic rst_n;
    logic pix_en;

    logic [10:0] a_x, a_y;
    logic        a_act, a_hs, a_vs, a_ls, a_fs;
    logic [10:0] b_x, b_y;
    logic        b_act, b_hs, b_vs, b_ls, b_fs;

    int tests_run = 0;
    int tests_failed = 0;

    // Small raster: 15 x 8, hsync x=10..12, vsync y=5..6, active 8x4.
    localparam int BHT = 15;
    localparam int BVT = 8;

    xga_timing_gen dut_a (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .pix_x(a_x), .pix_y(a_y), .video_active(a_act),
        .hsync(a_hs), .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs)
`ifdef XGA_FRAME_COUNT_EN
        , .frame_count()
`endif
    );

    xga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .pix_x(b_x), .pix_y(b_y), .video_active(b_act),
        .hsync(b_hs), .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs)
`ifdef XGA_FRAME_COUNT_EN
        , .frame_count()
`endif
    );

`ifdef XGA_FRAME_COUNT_EN
    logic [10:0] c_x, c_y;
    logic        c_act, c_hs, c_vs, c_ls, c_fs;
    logic [9:0]  c_fc;
    // Tiny 5 x 5 raster so 1025 frames stay short.
    xga_timing_gen #(
        .H_ACTIVE(2), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .pix_x(c_x), .pix_y(c_y), .video_active(c_act),
        .hsync(c_hs), .vsync(c_vs), .line_start(c_ls), .frame_start(c_fs),
        .frame_count(c_fc)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model for the small instance.
    int bx, by, b_bad;
    bit bls, bfs;

    task automatic b_model_step(input bit en);
        bit wrap;
        wrap = (bx == BHT - 1);
        if (en) begin
            bls = wrap;
            bfs = wrap && (by == BVT - 1);
            if (wrap) begin
                bx = 0;
                by = (by == BVT - 1) ? 0 : by + 1;
            end else begin
                bx = bx + 1;
            end
        end else begin
            bls = 1'b0;
            bfs = 1'b0;
        end
    endtask

    task automatic b_compare();
        bit e_act, e_hs, e_vs;
        e_act = (bx < 8) && (by < 4);
        e_hs  = !((bx >= 10) && (bx < 13));
        e_vs  = !((by >= 5) && (by < 7));
        if (b_x !== 11'(bx) || b_y !== 11'(by) || b_act !== e_act || b_hs !== e_hs ||
            b_vs !== e_vs || b_ls !== bls || b_fs !== bfs) begin
            if (b_bad < 4)
                $display("  small raster differs at model (%0d,%0d): dut (%0d,%0d) act=%0b hs=%0b vs=%0b ls=%0b fs=%0b",
                         bx, by, b_x, b_y, b_act, b_hs, b_vs, b_ls, b_fs);
            b_bad++;
        end
    endtask

    initial begin
        int period, hs_low, first_low, act_cnt, vs_bad, x_bad, exp_x;
        int vs_low, fs_seen, fs_at, ax0;

        rst_n = 1'b0;
        pix_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_x", a_x, 1343);
        check("rst_a_y", a_y, 805);
        check("rst_a_active", a_act, 0);
        check("rst_a_hsync", a_hs, 1);
        check("rst_a_vsync", a_vs, 1);
        check("rst_a_line_start", a_ls, 0);
        check("rst_a_frame_start", a_fs, 0);
        check("rst_b_x", b_x, 14);
        check("rst_b_y", b_y, 7);

        @(negedge clk) rst_n = 1'b1;
        tick();
        check("first_a_x", a_x, 0);
        check("first_a_y", a_y, 0);
        check("first_a_active", a_act, 1);
        check("first_a_hsync", a_hs, 1);
        check("first_a_line_start", a_ls, 1);
        check("first_a_frame_start", a_fs, 1);
        check("first_b_frame_start", b_fs, 1);

        // Line 0 of the full raster, observed pixel by pixel.
        period = 0; hs_low = 0; first_low = -1; act_cnt = 1; vs_bad = 0; x_bad = 0; exp_x = 0;
        do begin
            tick();
            period++;
            exp_x++;
            if (period == 1) begin
                check("second_a_line_start", a_ls, 0);
                check("second_a_frame_start", a_fs, 0);
            end
            if (!a_ls) begin
                if (a_x !== 11'(exp_x) || a_y !== 11'd0) x_bad++;
                if (!a_hs) begin
                    hs_low++;
                    if (first_low < 0) first_low = int'(a_x);
                end
                if (a_act) act_cnt++;
                if (a_vs !== 1'b1) vs_bad++;
            end
        end while (!a_ls && period < 2000);
        check("line_period", period, 1344);
        check("line_hsync_low_count", hs_low, 136);
        check("line_hsync_first_x", first_low, 1048);
        check("line_active_count", act_cnt, 1024);
        check("line_position_errors", x_bad, 0);
        check("line_vsync_errors", vs_bad, 0);
        check("line1_x", a_x, 0);
        check("line1_y", a_y, 1);
        check("line1_frame_start", a_fs, 0);

        // Full frame on the small raster.
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        pix_en = 1'b1;
        tick();
        bx = 0; by = 0; bls = 1'b1; bfs = 1'b1; b_bad = 0;
        b_compare();
        vs_low = 0; act_cnt = 0; fs_seen = 0; fs_at = -1;
        for (int i = 1; i <= BHT * BVT; i++) begin
            b_model_step(1'b1);
            tick();
            b_compare();
            if (!b_vs) vs_low++;
            if (b_act) act_cnt++;
            if (b_fs) begin
                fs_seen++;
                fs_at = i;
            end
        end
        check("frame_model_errors", b_bad, 0);
        check("frame_vsync_low_clks", vs_low, 30);
        check("frame_active_clks", act_cnt, 32);
        check("frame_start_count", fs_seen, 1);
        check("frame_start_period", fs_at, 120);

        // pix_en alternating: advance every second clock only.
        b_bad = 0;
        ax0 = int'(a_x);
        for (int i = 0; i < 40; i++) begin
            pix_en = (i % 2 == 0);
            b_model_step(pix_en);
            tick();
            b_compare();
        end
        check("toggle_model_errors", b_bad, 0);
        check("toggle_a_advance", int'(a_x), (ax0 + 20) % 1344);

        // Asynchronous reset in the middle of a clock period.
        pix_en = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_a_x", a_x, 1343);
        check("async_a_y", a_y, 805);
        check("async_a_active", a_act, 0);
        check("async_a_hsync", a_hs, 1);
        check("async_a_vsync", a_vs, 1);
        check("async_b_x", b_x, 14);
        check("async_b_y", b_y, 7);
`ifdef XGA_FRAME_COUNT_EN
        check("async_c_frame_count", c_fc, 0);
`endif
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("resume_a_x", a_x, 0);
        check("resume_a_y", a_y, 0);
        check("resume_a_frame_start", a_fs, 1);
        check("resume_a_line_start", a_ls, 1);
        check("resume_b_frame_start", b_fs, 1);
`ifdef XGA_FRAME_COUNT_EN
        check("fc_first", c_fc, 1);
        check("fc_first_fs", c_fs, 1);
        fs_seen = 1;
        for (int i = 0; i < 1024 * 25; i++) begin
            tick();
            if (c_fs) fs_seen++;
        end
        check("fc_frames", fs_seen, 1025);
        check("fc_wrap_fs", c_fs, 1);
        check("fc_wrap_value", c_fc, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
